// File: rtl/tl45_fetch.sv
// TL45 instruction fetch: a single-outstanding Wishbone B4 pipelined master that feeds
// the fetch->decode buffer. A one-entry skid holds a word acked during a decode stall.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_flush_pc,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic        pend_valid_r;
  logic        pend_valid_nxt_s;
  logic [31:0] pend_pc_r;
  logic [31:0] pend_pc_nxt_s;
  logic [31:0] pend_inst_r;
  logic [31:0] pend_inst_nxt_s;
  logic [31:0] buf_pc_nxt_s;
  logic [31:0] buf_inst_nxt_s;
  logic        fetch_err_nxt_s;
  logic        wb_cyc_nxt_s;
  logic        wb_stb_nxt_s;
  logic        req_accept_s;

  assign req_accept_s = o_wb_stb && !i_wb_stall;
  assign o_wb_addr    = pc_r[31:2];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_ISSUE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an error ack outranks a data ack.
  always_comb begin
    state_nxt_s = state_r;
    if (i_pipe_flush) begin
      state_nxt_s = ST_ISSUE;
    end else begin
      case (state_r)
        ST_ISSUE: begin
          if (req_accept_s) state_nxt_s = ST_WAIT;
          else              state_nxt_s = ST_ISSUE;
        end
        ST_WAIT: begin
          if (i_wb_err)          state_nxt_s = ST_ERROR;
          else if (!i_wb_ack)    state_nxt_s = ST_WAIT;
          else if (i_pipe_stall) state_nxt_s = ST_HOLD;
          else                   state_nxt_s = ST_ISSUE;
        end
        ST_HOLD: begin
          if (i_pipe_stall) state_nxt_s = ST_HOLD;
          else              state_nxt_s = ST_ISSUE;
        end
        ST_ERROR: state_nxt_s = ST_ERROR;
        default:  state_nxt_s = ST_ISSUE;
      endcase
    end
  end

  // Output and datapath next values; a non-stalled cycle that loads nothing becomes a bubble.
  always_comb begin
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    pend_inst_nxt_s  = pend_inst_r;
    fetch_err_nxt_s  = o_fetch_err;
    wb_cyc_nxt_s     = o_wb_cyc;
    wb_stb_nxt_s     = o_wb_stb;
    if (i_pipe_stall) begin
      buf_pc_nxt_s   = o_buf_pc;
      buf_inst_nxt_s = o_buf_inst;
    end else begin
      buf_pc_nxt_s   = 32'h0000_0000;
      buf_inst_nxt_s = 32'h0000_0000;
    end

    if (i_pipe_flush) begin
      pc_nxt_s         = i_flush_pc & 32'hFFFF_FFFC;
      buf_pc_nxt_s     = 32'h0000_0000;
      buf_inst_nxt_s   = 32'h0000_0000;
      pend_valid_nxt_s = 1'b0;
      fetch_err_nxt_s  = 1'b0;
      wb_cyc_nxt_s     = 1'b0;
      wb_stb_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        ST_ISSUE: begin
          // The first ISSUE cycle raises the request; it drops once the slave takes it.
          if (!o_wb_stb) begin
            wb_cyc_nxt_s = 1'b1;
            wb_stb_nxt_s = 1'b1;
          end else if (!i_wb_stall) begin
            wb_stb_nxt_s = 1'b0;
          end else begin
            wb_stb_nxt_s = 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_wb_err) begin
            wb_cyc_nxt_s    = 1'b0;
            fetch_err_nxt_s = 1'b1;
          end else if (i_wb_ack) begin
            wb_cyc_nxt_s = 1'b0;
            pc_nxt_s     = pc_r + 32'd4;
            if (i_pipe_stall) begin
              pend_valid_nxt_s = 1'b1;
              pend_pc_nxt_s    = pc_r;
              pend_inst_nxt_s  = i_wb_data;
            end else begin
              buf_pc_nxt_s   = pc_r;
              buf_inst_nxt_s = i_wb_data;
            end
          end else begin
            wb_cyc_nxt_s = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!i_pipe_stall) begin
            buf_pc_nxt_s     = pend_pc_r;
            buf_inst_nxt_s   = pend_inst_r;
            pend_valid_nxt_s = 1'b0;
          end else begin
            pend_valid_nxt_s = pend_valid_r;
          end
        end
        ST_ERROR: begin
          wb_cyc_nxt_s = 1'b0;
          wb_stb_nxt_s = 1'b0;
        end
        default: begin
          wb_cyc_nxt_s = 1'b0;
          wb_stb_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_r         <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
      pend_inst_r  <= 32'h0000_0000;
      o_buf_pc     <= 32'h0000_0000;
      o_buf_inst   <= 32'h0000_0000;
      o_fetch_err  <= 1'b0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
    end else begin
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
      pend_inst_r  <= pend_inst_nxt_s;
      o_buf_pc     <= buf_pc_nxt_s;
      o_buf_inst   <= buf_inst_nxt_s;
      o_fetch_err  <= fetch_err_nxt_s;
      o_wb_cyc     <= wb_cyc_nxt_s;
      o_wb_stb     <= wb_stb_nxt_s;
    end
  end

endmodule

// File: tb/tb_tl45_fetch.sv
// Directed bench for tl45_fetch: a zero-wait Wishbone slave plus a transaction-level
// model of what decode must see, compared every cycle, with literal checks on key points.
module tb_tl45_fetch;

  logic        i_clk;
  logic        i_reset;
  logic        i_pipe_stall;
  logic        i_pipe_flush;
  logic [31:0] i_flush_pc;
  logic [31:0] o_buf_pc;
  logic [31:0] o_buf_inst;
  logic        o_fetch_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [29:0] o_wb_addr;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_data;

  tl45_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall),
    .i_pipe_flush(i_pipe_flush), .i_flush_pc(i_flush_pc),
    .o_buf_pc(o_buf_pc), .o_buf_inst(o_buf_inst), .o_fetch_err(o_fetch_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acks  = 0;

  // Slave state
  logic        s_acc = 1'b0;
  logic [29:0] s_addr = 30'h0;
  logic        s_stalled = 1'b0;
  logic [29:0] s_stalled_addr = 30'h0;
  logic [29:0] err_word = 30'h0000_1234;

  // Decode-side model
  logic [31:0] m_pc, m_out_pc, m_out_inst, m_pend_pc, m_pend_inst;
  logic        m_err, m_halt, m_pend_v, m_outst;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h0800_0000;
      30'd1:   return 32'h1000_0001;
      30'd2:   return 32'hDEAD_BEEF;
      default: return 32'hA000_0000 | {2'b00, a};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: slave response, pre-edge bus checks, edge, model step, output checks.
  task automatic tick();
    logic        c_acc;
    logic [29:0] c_addr;
    logic        c_stalled;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    i_wb_data = 32'h0;
    if (s_acc) begin
      if (s_addr == err_word) begin
        i_wb_err = 1'b1;
      end else begin
        i_wb_ack  = 1'b1;
        i_wb_data = mem_word(s_addr);
        n_acks++;
      end
    end
    #1;
    c_acc     = o_wb_stb && !i_wb_stall;
    c_addr    = o_wb_addr;
    c_stalled = o_wb_stb && i_wb_stall && !i_pipe_flush && !i_reset;
    if (!i_reset) begin
      check("stb_implies_cyc", 64'(!o_wb_stb || o_wb_cyc), 64'h1);
      if (m_halt || m_pend_v) check("stb_while_blocked", 64'(o_wb_stb), 64'h0);
      if (m_outst) check("one_outstanding", 64'(c_acc), 64'h0);
      if (c_acc) check("fetch_addr", 64'(c_addr), 64'(m_pc[31:2]));
      if (s_stalled) check("addr_stable", 64'({o_wb_stb, o_wb_addr}), 64'({1'b1, s_stalled_addr}));
    end
    @(posedge i_clk);
    #1;
    if (i_reset) begin
      m_pc = 32'h0; m_out_pc = 32'h0; m_out_inst = 32'h0;
      m_err = 1'b0; m_halt = 1'b0; m_pend_v = 1'b0; m_outst = 1'b0;
      check("reset_bus", 64'({o_wb_cyc, o_wb_stb}), 64'h0);
    end else if (i_pipe_flush) begin
      m_pc = i_flush_pc & 32'hFFFF_FFFC; m_out_pc = 32'h0; m_out_inst = 32'h0;
      m_err = 1'b0; m_halt = 1'b0; m_pend_v = 1'b0; m_outst = 1'b0;
    end else begin
      if (m_outst && i_wb_err) begin
        m_outst = 1'b0; m_err = 1'b1; m_halt = 1'b1;
        if (!i_pipe_stall) begin m_out_pc = 32'h0; m_out_inst = 32'h0; end
      end else if (m_outst && i_wb_ack) begin
        m_outst = 1'b0;
        if (!i_pipe_stall) begin m_out_pc = m_pc; m_out_inst = i_wb_data; end
        else begin m_pend_v = 1'b1; m_pend_pc = m_pc; m_pend_inst = i_wb_data; end
        m_pc = m_pc + 32'd4;
      end else if (!i_pipe_stall) begin
        if (m_pend_v) begin m_out_pc = m_pend_pc; m_out_inst = m_pend_inst; m_pend_v = 1'b0; end
        else begin m_out_pc = 32'h0; m_out_inst = 32'h0; end
      end
      if (c_acc) m_outst = 1'b1;
    end
    check("buf_pc", 64'(o_buf_pc), 64'(m_out_pc));
    check("buf_inst", 64'(o_buf_inst), 64'(m_out_inst));
    check("fetch_err", 64'(o_fetch_err), 64'(m_err));
    if (m_halt) check("cyc_in_error", 64'(o_wb_cyc), 64'h0);
    s_acc          = c_acc && !i_pipe_flush && !i_reset;
    s_addr         = c_addr;
    s_stalled      = c_stalled;
    s_stalled_addr = c_addr;
    @(negedge i_clk);
  endtask

  task automatic run_until_inst(input int bound);
    int n;
    n = 0;
    tick();
    while (o_buf_inst == 32'h0 && n < bound) begin
      tick();
      n++;
    end
    check("deliver_timeout", 64'(o_buf_inst != 32'h0), 64'h1);
  endtask

  task automatic flush_to(input logic [31:0] target);
    i_pipe_flush = 1'b1;
    i_flush_pc   = target;
    tick();
    i_pipe_flush = 1'b0;
  endtask

  initial begin
    int ack0;
    int cyc_seen;
    i_reset = 1'b1; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0; i_flush_pc = 32'h0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0;
    @(negedge i_clk);
    tick();
    tick();
    check("reset_outputs", {o_buf_pc, o_buf_inst}, 64'h0);
    i_reset = 1'b0;

    // Zero-wait fetches from address 0 and 1, with a bubble in between.
    run_until_inst(10);
    check("first_inst", {o_buf_pc, o_buf_inst}, {32'h0000_0000, 32'h0800_0000});
    tick();
    check("bubble", {o_buf_pc, o_buf_inst}, 64'h0);
    run_until_inst(10);
    check("second_inst", {o_buf_pc, o_buf_inst}, {32'h0000_0004, 32'h1000_0001});

    // Decode stall held across the ack for address 2.
    i_pipe_stall = 1'b1;
    repeat (6) tick();
    check("stall_hold", {o_buf_pc, o_buf_inst}, {32'h0000_0004, 32'h1000_0001});
    i_pipe_stall = 1'b0;
    tick();
    check("skid_release", {o_buf_pc, o_buf_inst}, {32'h0000_0008, 32'hDEAD_BEEF});
    tick();
    check("issue_after_skid", 64'({o_wb_stb, o_wb_addr}), 64'({1'b1, 30'h3}));

    // Slave stall for four cycles at pc 0x40.
    flush_to(32'h0000_0040);
    tick();
    ack0 = n_acks;
    i_wb_stall = 1'b1;
    repeat (4) begin
      tick();
      check("wb_stall_stable", 64'({o_wb_stb, o_wb_addr}), 64'({1'b1, 30'h10}));
    end
    i_wb_stall = 1'b0;
    run_until_inst(10);
    check("wb_stall_inst", {o_buf_pc, o_buf_inst}, {32'h0000_0040, 32'hA000_0010});
    check("wb_stall_one_ack", 64'(n_acks - ack0), 64'h1);

    // Flush in the WAIT cycle that also carries the ack.
    tick();
    tick();
    flush_to(32'h0000_0103);
    check("flush_clears", {o_buf_pc, o_buf_inst}, 64'h0);
    tick();
    check("flush_addr", 64'({o_wb_stb, o_wb_addr}), 64'({1'b1, 30'h40}));
    run_until_inst(10);
    check("flush_inst", {o_buf_pc, o_buf_inst}, {32'h0000_0100, 32'hA000_0040});

    // Bus error at pc 0x20, then recovery by flush.
    err_word = 30'h8;
    flush_to(32'h0000_0020);
    repeat (3) tick();
    check("err_set", 64'(o_fetch_err), 64'h1);
    check("err_outputs", {o_buf_pc, o_buf_inst}, 64'h0);
    cyc_seen = 0;
    repeat (10) begin
      tick();
      if (o_wb_cyc) cyc_seen++;
    end
    check("err_no_cyc", 64'(cyc_seen), 64'h0);
    err_word = 30'h0000_1234;
    flush_to(32'h0000_0000);
    check("err_cleared", 64'(o_fetch_err), 64'h0);
    tick();
    check("err_resume_addr", 64'({o_wb_stb, o_wb_addr}), 64'({1'b1, 30'h0}));
    run_until_inst(10);
    check("err_resume_inst", {o_buf_pc, o_buf_inst}, {32'h0000_0000, 32'h0800_0000});

    // PC wraparound.
    flush_to(32'hFFFF_FFFC);
    run_until_inst(10);
    check("wrap_inst", {o_buf_pc, o_buf_inst}, {32'hFFFF_FFFC, 32'hBFFF_FFFF});
    tick();
    check("wrap_addr", 64'({o_wb_stb, o_wb_addr}), 64'({1'b1, 30'h0}));

    // Flush while the skid holds a word and decode keeps stalling.
    i_pipe_stall = 1'b1;
    tick();
    tick();
    flush_to(32'h0000_0200);
    check("flush_in_hold", {o_buf_pc, o_buf_inst}, 64'h0);
    tick();
    check("flush_stalled_issue", 64'({o_wb_stb, o_wb_addr}), 64'({1'b1, 30'h80}));
    i_pipe_stall = 1'b0;
    run_until_inst(10);
    check("flush_stalled_inst", {o_buf_pc, o_buf_inst}, {32'h0000_0200, 32'hA000_0080});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
